race_lap_tracker: RTL and testbench
===================================

Name: race_lap_tracker

Overview:
- Per-kart race progress block: checks the kart position against NUM_CP parameterised checkpoint rectangles that must be visited in order, and counts laps up to NUM_LAPS.
- Times each lap in game ticks, keeps the best lap, raises finish, and flags wrong-way driving.
- Generalises the hard-coded 4-flag checkpoint chain: checkpoint count, geometry, lap count and timing are all parameters.
- Sits beside each kart's physics engine; the kart's position outputs feed it and the HUD and game FSM consume its outputs.

Parameters:
NUM_CP, 4, number of checkpoints (>=3); index NUM_CP-1 is the finish line.
CP_W, 3, width of checkpoint index; 2**CP_W >= NUM_CP.
NUM_LAPS, 3, laps needed to finish (1..15).
CP_RECTS, 160'h0, packed rectangles, NUM_CP*40 bits; checkpoint k occupies bits [40k+39:40k] = {x_min, x_max, y_min, y_max}, 10 bits each, bounds inclusive.
CLK_FREQ, 100_000_000, clock frequency in Hz.
TICK_HZ, 120, timer tick rate in Hz.
TIMER_W, 16, width of the lap timers.
RUN_STATE, 3'd4, game-FSM code in which the block tracks progress.
IDLE_STATE, 3'd0, game-FSM code that re-arms the block.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst=0 resets)
state  in  3  game FSM state
pos_x  in  10  kart reference x, pixels
pos_y  in  10  kart reference y, pixels
next_cp  out  CP_W  index of next expected checkpoint
lap_count  out  4  completed laps
lap_time  out  TIMER_W  ticks elapsed in current lap
best_lap  out  TIMER_W  fastest completed lap; all-ones = none yet
cp_pulse  out  1  one-clk pulse on each valid checkpoint hit
lap_pulse  out  1  one-clk pulse on lap completion
wrong_way  out  1  level, kart is driving backwards
finish  out  1  level, all laps done

Behaviour:
- Reset (rst=0 at posedge): next_cp=0, lap_count=0, lap_time=0, best_lap=all-ones, cp_pulse=0, lap_pulse=0, wrong_way=0, finish=0, armed=1, tick divider=0. Reset overrides every other input, including mid-lap.
- state==IDLE_STATE: clears everything to reset values except best_lap, which is retained across races.
- state not RUN and not IDLE: all registers hold, divider paused, no detection, pulses 0.
- Tick divider: counts 0..CLK_FREQ/TICK_HZ-1 in RUN state only. tick is high on the terminal count, then the counter wraps to 0.
- lap_time: +1 per tick, saturating at all-ones.
- Hit test is combinational: in_k = x_min<=pos_x<=x_max && y_min<=pos_y<=y_max. All outputs are registered, so a position sampled at edge N produces its response after edge N (1-clk latency).
- Valid hit when in_{next_cp} && armed && !finish:
  - cp_pulse=1 for one clk; last_cp<=next_cp; armed<=0; wrong_way<=0.
  - next_cp<=next_cp+1, or 0 when next_cp==NUM_CP-1.
- Re-arm: armed<=1 once !in_{last_cp}. This prevents repeat counting while the kart stays inside a rectangle.
- Lap completion (valid hit on index NUM_CP-1):
  - lap_pulse=1 in the same cycle as cp_pulse.
  - lap_count+1.
  - best_lap<=min(best_lap, lap_time), using the registered lap_time value.
  - lap_time<=0; a coincident tick is discarded.
- Finish: if lap_count+1==NUM_LAPS on completion, finish<=1 in the same cycle as lap_pulse. From then on, lap_time, lap_count and next_cp freeze and no further hits are counted until IDLE or reset.
- Wrong way: wrong_way<=1 when in_p with p = last_cp-1 mod NUM_CP (the checkpoint before the last one passed), no valid hit that cycle, and at least one checkpoint passed since IDLE. Cleared only by the next valid hit, IDLE, or reset.
- Overlapping rectangles: only the next expected index can produce a hit.

Test Plan:
- Setup for all scenarios unless stated: CLK_FREQ=1200, TICK_HZ=120 (tick every 10 clk), NUM_CP=3, NUM_LAPS=2, RUN state.
- Drive pos through rect0, rect1, rect2 in order → cp_pulse 3 times; lap_pulse with the rect2 pulse; lap_count=1; next_cp=0; lap_time=0; best_lap=lap ticks (e.g. 7 for 75 clk).
- Park inside rect0 for 50 clk → exactly one cp_pulse; next_cp=1. Leave, then re-enter rect0 → no pulse.
- Enter rect2 when next_cp=1 → no pulse, next_cp stays 1. Then hit rect1, leave, re-enter rect0 → wrong_way=1. Next entry into rect2 → cp_pulse, wrong_way=0.
- Two laps of 9 then 5 ticks → best_lap=5, finish=1 with the second lap_pulse. Further rect0 entries → no pulse; lap_time stays 0.
- Mid-lap, set state=3'd5 for 100 clk → lap_time and divider frozen. Then pull rst=0 for 1 clk → all outputs at reset values, best_lap=FFFF.
- After a 5-tick finish, go IDLE then RUN → lap_count=0, finish=0, best_lap still 5.

Source files
------------

// File: rtl/race_lap_tracker.sv
// rtl/race_lap_tracker.sv - per-kart checkpoint sequencing, lap counting, lap timing and wrong-way detection
module race_lap_tracker #(
    parameter int                     NUM_CP     = 4,
    parameter int                     CP_W       = 3,
    parameter int                     NUM_LAPS   = 3,
    parameter logic [NUM_CP*40-1:0]   CP_RECTS   = '0,
    parameter int                     CLK_FREQ   = 100_000_000,
    parameter int                     TICK_HZ    = 120,
    parameter int                     TIMER_W    = 16,
    parameter logic [2:0]             RUN_STATE  = 3'd4,
    parameter logic [2:0]             IDLE_STATE = 3'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         state,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    output logic [CP_W-1:0]    next_cp,
    output logic [3:0]         lap_count,
    output logic [TIMER_W-1:0] lap_time,
    output logic [TIMER_W-1:0] best_lap,
    output logic               cp_pulse,
    output logic               lap_pulse,
    output logic               wrong_way,
    output logic               finish
);

    localparam int               DIV      = CLK_FREQ / TICK_HZ;
    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CP_W-1:0]  LAST_CP  = CP_W'(NUM_CP - 1);
    localparam logic [3:0]       LAPS     = 4'(NUM_LAPS);

    logic [CP_W-1:0]    next_cp_q,   next_cp_d;
    logic [CP_W-1:0]    last_cp_q,   last_cp_d;
    logic [3:0]         lap_count_q, lap_count_d;
    logic [TIMER_W-1:0] lap_time_q,  lap_time_d;
    logic [TIMER_W-1:0] best_lap_q,  best_lap_d;
    logic [DIV_W-1:0]   div_q,       div_d;
    logic               cp_pulse_q,  cp_pulse_d;
    logic               lap_pulse_q, lap_pulse_d;
    logic               wrong_way_q, wrong_way_d;
    logic               finish_q,    finish_d;
    logic               armed_q,     armed_d;
    logic               visited_q,   visited_d;

    // Padded to a power of two so any CP_W-wide index selects a defined bit.
    logic [2**CP_W-1:0] in_vec;
    logic [CP_W-1:0]    prev_cp;
    logic               tick;
    logic               valid_hit;

    always_comb begin
        in_vec = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            in_vec[k] = (pos_x >= CP_RECTS[40*k+30 +: 10]) && (pos_x <= CP_RECTS[40*k+20 +: 10]) &&
                        (pos_y >= CP_RECTS[40*k+10 +: 10]) && (pos_y <= CP_RECTS[40*k    +: 10]);
        end
    end

    assign prev_cp   = (last_cp_q == '0) ? LAST_CP : last_cp_q - 1'b1;
    assign tick      = (div_q == DIV_LAST);
    assign valid_hit = in_vec[next_cp_q] && armed_q && !finish_q;

    always_comb begin
        next_cp_d   = next_cp_q;
        last_cp_d   = last_cp_q;
        lap_count_d = lap_count_q;
        lap_time_d  = lap_time_q;
        best_lap_d  = best_lap_q;
        div_d       = div_q;
        cp_pulse_d  = 1'b0;
        lap_pulse_d = 1'b0;
        wrong_way_d = wrong_way_q;
        finish_d    = finish_q;
        armed_d     = armed_q;
        visited_d   = visited_q;

        if (state == IDLE_STATE) begin
            next_cp_d   = '0;
            last_cp_d   = '0;
            lap_count_d = '0;
            lap_time_d  = '0;
            div_d       = '0;
            wrong_way_d = 1'b0;
            finish_d    = 1'b0;
            armed_d     = 1'b1;
            visited_d   = 1'b0;
        end else if (state == RUN_STATE) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick && !finish_q && (lap_time_q != '1)) begin
                lap_time_d = lap_time_q + 1'b1;
            end
            if (!armed_q && !in_vec[last_cp_q]) begin
                armed_d = 1'b1;
            end

            if (valid_hit) begin
                cp_pulse_d  = 1'b1;
                last_cp_d   = next_cp_q;
                armed_d     = 1'b0;
                wrong_way_d = 1'b0;
                visited_d   = 1'b1;
                next_cp_d   = (next_cp_q == LAST_CP) ? '0 : next_cp_q + 1'b1;
                // Finish-line hit closes the lap; the registered time is the lap time.
                if (next_cp_q == LAST_CP) begin
                    lap_pulse_d = 1'b1;
                    lap_count_d = lap_count_q + 4'd1;
                    lap_time_d  = '0;
                    if (lap_time_q < best_lap_q) begin
                        best_lap_d = lap_time_q;
                    end
                    if (lap_count_q + 4'd1 == LAPS) begin
                        finish_d = 1'b1;
                    end
                end
            end else if (visited_q && in_vec[prev_cp]) begin
                wrong_way_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            next_cp_q   <= '0;
            last_cp_q   <= '0;
            lap_count_q <= '0;
            lap_time_q  <= '0;
            best_lap_q  <= '1;
            div_q       <= '0;
            cp_pulse_q  <= 1'b0;
            lap_pulse_q <= 1'b0;
            wrong_way_q <= 1'b0;
            finish_q    <= 1'b0;
            armed_q     <= 1'b1;
            visited_q   <= 1'b0;
        end else begin
            next_cp_q   <= next_cp_d;
            last_cp_q   <= last_cp_d;
            lap_count_q <= lap_count_d;
            lap_time_q  <= lap_time_d;
            best_lap_q  <= best_lap_d;
            div_q       <= div_d;
            cp_pulse_q  <= cp_pulse_d;
            lap_pulse_q <= lap_pulse_d;
            wrong_way_q <= wrong_way_d;
            finish_q    <= finish_d;
            armed_q     <= armed_d;
            visited_q   <= visited_d;
        end
    end

    assign next_cp   = next_cp_q;
    assign lap_count = lap_count_q;
    assign lap_time  = lap_time_q;
    assign best_lap  = best_lap_q;
    assign cp_pulse  = cp_pulse_q;
    assign lap_pulse = lap_pulse_q;
    assign wrong_way = wrong_way_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_race_lap_tracker.sv
// tb/tb_race_lap_tracker.sv - directed checks of race_lap_tracker with 3 checkpoints, 2 laps, tick every 10 clk
module tb_race_lap_tracker;

    localparam logic [119:0] RECTS = {10'd200, 10'd219, 10'd10, 10'd19,
                                      10'd100, 10'd119, 10'd10, 10'd19,
                                      10'd10,  10'd19,  10'd10, 10'd19};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [1:0]  next_cp;
    logic [3:0]  lap_count;
    logic [15:0] lap_time;
    logic [15:0] best_lap;
    logic        cp_pulse;
    logic        lap_pulse;
    logic        wrong_way;
    logic        finish;

    int vectors = 0;
    int errs    = 0;
    int cp_cnt  = 0;

    race_lap_tracker #(
        .NUM_CP(3), .CP_W(2), .NUM_LAPS(2), .CP_RECTS(RECTS),
        .CLK_FREQ(1200), .TICK_HZ(120), .TIMER_W(16),
        .RUN_STATE(3'd4), .IDLE_STATE(3'd0)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .pos_x(pos_x), .pos_y(pos_y),
        .next_cp(next_cp), .lap_count(lap_count), .lap_time(lap_time), .best_lap(best_lap),
        .cp_pulse(cp_pulse), .lap_pulse(lap_pulse), .wrong_way(wrong_way), .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (cp_pulse === 1'b1) cp_cnt++;
        end
    endtask

    // 0..2 = centre of that checkpoint rectangle, anything else = off all rectangles
    task automatic go(input int r);
        case (r)
            0:       begin pos_x = 10'd15;  pos_y = 10'd15;  end
            1:       begin pos_x = 10'd110; pos_y = 10'd15;  end
            2:       begin pos_x = 10'd210; pos_y = 10'd15;  end
            default: begin pos_x = 10'd500; pos_y = 10'd500; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_next_cp"},   32'(next_cp),   32'd0);
        check({tag, "_lap_count"}, 32'(lap_count), 32'd0);
        check({tag, "_lap_time"},  32'(lap_time),  32'd0);
        check({tag, "_best_lap"},  32'(best_lap),  32'hFFFF);
        check({tag, "_cp_pulse"},  32'(cp_pulse),  32'd0);
        check({tag, "_lap_pulse"}, 32'(lap_pulse), 32'd0);
        check({tag, "_wrong_way"}, 32'(wrong_way), 32'd0);
        check({tag, "_finish"},    32'(finish),    32'd0);
    endtask

    initial begin
        rst = 1'b0; state = 3'd0; go(3);
        run(3);
        check_reset_values("rst0");
        rst = 1'b1;
        run(1);

        // Race 1: lap of 7 ticks completes on RUN edge 75
        state = 3'd4;
        go(0); run(1);
        check("l1_cp0_pulse", 32'(cp_pulse), 32'd1);
        check("l1_cp0_next",  32'(next_cp),  32'd1);
        go(3); run(1);
        go(1); run(1);
        check("l1_cp1_next",  32'(next_cp),  32'd2);
        go(3); run(71);
        go(2); run(1);
        check("l1_cp2_pulse", 32'(cp_pulse),  32'd1);
        check("l1_lap_pulse", 32'(lap_pulse), 32'd1);
        check("l1_lap_count", 32'(lap_count), 32'd1);
        check("l1_next_wrap", 32'(next_cp),   32'd0);
        check("l1_time_clr",  32'(lap_time),  32'd0);
        check("l1_best",      32'(best_lap),  32'd7);
        check("l1_no_finish", 32'(finish),    32'd0);

        go(3); run(1);
        cp_cnt = 0;
        go(0); run(50);
        check("park_one_pulse", 32'(cp_cnt),  32'd1);
        check("park_next",      32'(next_cp), 32'd1);
        go(3); run(2);
        cp_cnt = 0;
        go(0); run(3);
        check("reenter_no_pulse", 32'(cp_cnt),   32'd0);
        check("l2_time_6",        32'(lap_time), 32'd6);

        go(2); run(2);
        check("skip_no_pulse", 32'(cp_cnt),    32'd0);
        check("skip_next",     32'(next_cp),   32'd1);
        check("skip_wrongway", 32'(wrong_way), 32'd1);
        go(1); run(1);
        check("cp1_pulse",     32'(cp_pulse),  32'd1);
        check("cp1_ww_clear",  32'(wrong_way), 32'd0);
        go(3); run(1);
        go(0); run(1);
        check("back_wrongway", 32'(wrong_way), 32'd1);
        go(3); run(1);
        check("ww_level",      32'(wrong_way), 32'd1);
        go(2); run(1);
        check("l2_cp_pulse",   32'(cp_pulse),  32'd1);
        check("l2_lap_pulse",  32'(lap_pulse), 32'd1);
        check("l2_ww_clear",   32'(wrong_way), 32'd0);
        check("l2_finish",     32'(finish),    32'd1);
        check("l2_lap_count",  32'(lap_count), 32'd2);
        check("l2_best",       32'(best_lap),  32'd6);
        go(3); run(2);
        cp_cnt = 0;
        go(0); run(3);
        go(3); run(20);
        check("fin_no_pulse", 32'(cp_cnt),   32'd0);
        check("fin_time",     32'(lap_time), 32'd0);
        check("fin_next",     32'(next_cp),  32'd0);

        state = 3'd0; run(2);
        check("idle1_count",  32'(lap_count), 32'd0);
        check("idle1_finish", 32'(finish),    32'd0);
        check("idle1_best",   32'(best_lap),  32'd6);
        check("idle1_next",   32'(next_cp),   32'd0);

        // Race 2: laps of 9 then 5 ticks
        state = 3'd4;
        go(0); run(1);
        go(3); run(1);
        go(1); run(1);
        go(3); run(91);
        go(2); run(1);
        check("r2l1_lap_pulse", 32'(lap_pulse), 32'd1);
        check("r2l1_count",     32'(lap_count), 32'd1);
        check("r2l1_best",      32'(best_lap),  32'd6);
        go(3); run(1);
        go(0); run(1);
        go(3); run(1);
        go(1); run(1);
        go(3); run(45);
        go(2); run(1);
        check("r2l2_lap_pulse", 32'(lap_pulse), 32'd1);
        check("r2l2_finish",    32'(finish),    32'd1);
        check("r2l2_best",      32'(best_lap),  32'd5);
        check("r2l2_count",     32'(lap_count), 32'd2);
        go(3); run(1);
        cp_cnt = 0;
        go(0); run(30);
        check("r2_fin_no_pulse", 32'(cp_cnt),   32'd0);
        check("r2_fin_time",     32'(lap_time), 32'd0);

        state = 3'd0; go(3); run(2);
        check("idle2_count",  32'(lap_count), 32'd0);
        check("idle2_finish", 32'(finish),    32'd0);
        check("idle2_best",   32'(best_lap),  32'd5);

        // Race 3: pause mid-lap in a non-RUN state, then reset
        state = 3'd4;
        go(0); run(1);
        check("r3_next", 32'(next_cp), 32'd1);
        go(3); run(34);
        check("r3_time_3", 32'(lap_time), 32'd3);
        state = 3'd5;
        cp_cnt = 0;
        go(1); run(50);
        go(3); run(47);
        check("pause_time",     32'(lap_time), 32'd3);
        check("pause_next",     32'(next_cp),  32'd1);
        check("pause_no_pulse", 32'(cp_cnt),   32'd0);
        state = 3'd4;
        run(4);
        check("resume_time_3", 32'(lap_time), 32'd3);
        run(1);
        check("resume_time_4", 32'(lap_time), 32'd4);
        rst = 1'b0;
        run(1);
        check_reset_values("rst_mid");
        rst = 1'b1;
        run(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
